// File: rtl/test_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// test_pattern_gen_if
//   Write-side bundle between the test-pattern generator and the DCFIFO that
//   feeds the DAC drive logic.
//
//   Signals:
//     fifo_wrusedw  DCFIFO write-side fill level (write-clock domain)
//     fifo_full     DCFIFO write-side full flag
//     fifo_wrreq    write strobe
//     fifo_data     32-bit YCbCr 4:2:2 word (Y0-Cb-Y1-Cr)
//     sof           marks the first word of a frame
//     eol           marks the last word of a line
//
//   Modports:
//     master  pattern source (drives wrreq/data/sof/eol)
//     slave   FIFO side (drives usedw/full)
// -----------------------------------------------------------------------------
interface test_pattern_gen_if #(
  parameter int USEDW_W = 11
);
  logic [USEDW_W-1:0] fifo_wrusedw;
  logic               fifo_full;
  logic               fifo_wrreq;
  logic [31:0]        fifo_data;
  logic               sof;
  logic               eol;

  modport master (
    input  fifo_wrusedw, fifo_full,
    output fifo_wrreq, fifo_data, sof, eol
  );

  modport slave (
    output fifo_wrusedw, fifo_full,
    input  fifo_wrreq, fifo_data, sof, eol
  );
endinterface

// File: rtl/test_pattern_gen.sv
// -----------------------------------------------------------------------------
// test_pattern_gen
//   Video test-pattern source writing YCbCr 4:2:2 words into the write side of
//   the DA output DCFIFO. Runs full frames of H_ACTIVE x V_ACTIVE words; each
//   line starts only when the FIFO has room for a whole line, and word issue
//   stalls while fifo_full is high.
//
//   Patterns (mode, latched at frame start together with solid_color):
//     0 colour bars, 1 grey steps, 2 solid colour, 3 checkerboard
//
//   Ports:
//     clk           DCFIFO write clock
//     rst_n         asynchronous active-low reset
//     da_init_done  asynchronous "DA chip ready", 2-flop synchronised
//     mode          pattern select
//     solid_color   word used by the solid pattern
//     bus           FIFO write-side interface (master modport)
//
//   Build option:
//     TPG_BORDER_EN  when defined, a 1-word white border overrides the pattern
//                    on the first/last column and first/last row.
// -----------------------------------------------------------------------------
module test_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 2048,
  parameter int USEDW_W    = 11,
  parameter int CHK_LOG2   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                da_init_done,
  input  logic [1:0]          mode,
  input  logic [31:0]         solid_color,
  test_pattern_gen_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    LINE       = 2'd2,
    LINE_END   = 2'd3
  } state_t;

  localparam logic [11:0] COL_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] ROW_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [8:0]  BAR_LAST  = 9'(H_ACTIVE / 8 - 1);
  // A line may start only if a whole line still fits behind the current fill.
  localparam logic [31:0] SPACE_THR = 32'(FIFO_DEPTH - H_ACTIVE);
  localparam logic [31:0] WHITE     = 32'hB480_B480;
  localparam logic [31:0] BLACK     = 32'h1080_1080;

  state_t      state_q, state_d;
  logic [1:0]  init_sync_q, init_sync_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic [8:0]  bar_pix_q, bar_pix_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] solid_q, solid_d;
  logic        wrreq_q, wrreq_d;
  logic [31:0] data_q, data_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;

  logic        sync_init_done;
  logic        space_ok;
  logic [7:0]  grey_y;
  logic [31:0] pattern_word;

  assign sync_init_done = init_sync_q[1];
  assign space_ok       = 32'(bus.fifo_wrusedw) <= SPACE_THR;

  // Pattern for the current (col, row) position using the frame-latched mode.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a value held (no latches).
    grey_y       = 8'd16 + ({5'd0, bar_idx_q} * 8'd28);
    pattern_word = BLACK;
    unique case (mode_q)
      2'd0: begin
        unique case (bar_idx_q)
          3'd0: pattern_word = 32'hA22C_A28E;
          3'd1: pattern_word = 32'h839C_832C;
          3'd2: pattern_word = 32'h7048_703A;
          3'd3: pattern_word = 32'h54B8_54C6;
          3'd4: pattern_word = 32'h4164_41D4;
          3'd5: pattern_word = 32'h23D4_2372;
          3'd6: pattern_word = BLACK;
          3'd7: pattern_word = WHITE;
        endcase
      end
      2'd1: pattern_word = {grey_y, 8'h80, grey_y, 8'h80};
      2'd2: pattern_word = solid_q;
      2'd3: pattern_word = (col_q[CHK_LOG2] ^ row_q[CHK_LOG2]) ? WHITE : BLACK;
    endcase
`ifdef TPG_BORDER_EN
    if (col_q == 12'd0 || col_q == COL_LAST || row_q == 12'd0 || row_q == ROW_LAST)
      pattern_word = WHITE;
`endif
  end

  // Next-state logic; outputs default to idle (wrreq low, data zero).
  always_comb begin
    state_d     = state_q;
    init_sync_d = {init_sync_q[0], da_init_done};
    col_d       = col_q;
    row_d       = row_q;
    bar_pix_d   = bar_pix_q;
    bar_idx_d   = bar_idx_q;
    mode_d      = mode_q;
    solid_d     = solid_q;
    wrreq_d     = 1'b0;
    data_d      = 32'h0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        row_d = 12'd0;
        if (sync_init_done) begin
          mode_d  = mode;
          solid_d = solid_color;
          state_d = WAIT_SPACE;
        end
      end

      WAIT_SPACE: begin
        if (space_ok) begin
          col_d     = 12'd0;
          bar_pix_d = 9'd0;
          bar_idx_d = 3'd0;
          state_d   = LINE;
        end
      end

      LINE: begin
        // A full FIFO holds every counter; nothing is issued this cycle.
        if (!bus.fifo_full) begin
          wrreq_d = 1'b1;
          data_d  = pattern_word;
          sof_d   = (col_q == 12'd0) && (row_q == 12'd0);
          eol_d   = (col_q == COL_LAST);
          col_d   = col_q + 12'd1;
          // Bar index advances every H_ACTIVE/8 words without a divider.
          if (bar_pix_q == BAR_LAST) begin
            bar_pix_d = 9'd0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_pix_d = bar_pix_q + 9'd1;
          end
          if (col_q == COL_LAST) state_d = LINE_END;
        end
      end

      LINE_END: begin
        if (row_q == ROW_LAST) begin
          // Frame boundary: the only point where a dropped init or a new
          // mode/solid colour is honoured.
          row_d = 12'd0;
          if (!sync_init_done) begin
            state_d = IDLE;
          end else begin
            mode_d  = mode;
            solid_d = solid_color;
            state_d = WAIT_SPACE;
          end
        end else begin
          row_d   = row_q + 12'd1;
          state_d = WAIT_SPACE;
        end
      end
    endcase
  end

  // NOTE: every flop here is a small control/datapath register, so all are
  // reset asynchronously; a reset mid-line clears the outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_sync_q <= 2'b00;
      col_q       <= 12'd0;
      row_q       <= 12'd0;
      bar_pix_q   <= 9'd0;
      bar_idx_q   <= 3'd0;
      mode_q      <= 2'd0;
      solid_q     <= 32'h0;
      wrreq_q     <= 1'b0;
      data_q      <= 32'h0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from values sampled at the same edge.
      state_q     <= state_d;
      init_sync_q <= init_sync_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bar_pix_q   <= bar_pix_d;
      bar_idx_q   <= bar_idx_d;
      mode_q      <= mode_d;
      solid_q     <= solid_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
    end
  end

  assign bus.fifo_wrreq = wrreq_q;
  assign bus.fifo_data  = data_q;
  assign bus.sof        = sof_q;
  assign bus.eol        = eol_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_test_pattern_gen
//   Self-checking bench for test_pattern_gen on a reduced 64x64 frame. A
//   monitor records every written word; scenario tasks consume the words and
//   compare them with a position-based reference model of the four patterns.
// -----------------------------------------------------------------------------
module tb_test_pattern_gen;

  localparam int H     = 64;
  localparam int V     = 64;
  localparam int DEPTH = 128;
  localparam int UW    = 8;
  localparam int CHK   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        da_init_done = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] solid_color = 32'h0;

  test_pattern_gen_if #(.USEDW_W(UW)) bus ();

  test_pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .USEDW_W(UW), .CHK_LOG2(CHK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .da_init_done (da_init_done),
    .mode         (mode),
    .solid_color  (solid_color),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    int          stamp;
  } word_t;

  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  logic  full_at_edge = 1'b0;
  word_t q[$];
  int    idle_nonzero = 0;
  int    stall_viol   = 0;
  int    sof_eol_both = 0;

  // Reference-model position and frame configuration.
  int          exp_col = 0;
  int          exp_row = 0;
  logic [1:0]  frame_mode = 2'd0;
  logic [1:0]  next_mode  = 2'd0;
  logic [31:0] frame_solid = 32'h0;
  logic [31:0] next_solid  = 32'h0;
  int          words_since_sof = -1;
  int          last_stamp = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    full_at_edge <= bus.fifo_full;
  end

  always @(negedge clk) begin
    if (bus.fifo_wrreq) begin
      q.push_back('{data: bus.fifo_data, sof: bus.sof, eol: bus.eol, stamp: cyc});
      if (full_at_edge) stall_viol++;
      if (bus.sof && bus.eol) sof_eol_both++;
    end else if (bus.fifo_data !== 32'h0 || bus.sof !== 1'b0 || bus.eol !== 1'b0) begin
      idle_nonzero++;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input logic [1:0] m, input logic [31:0] s,
                                             input int col, input int row);
    int         bar;
    logic [7:0] y;
`ifdef TPG_BORDER_EN
    if (col == 0 || col == H - 1 || row == 0 || row == V - 1) return 32'hB480_B480;
`endif
    bar = col / (H / 8);
    case (m)
      2'd0: begin
        case (bar)
          0: return 32'hA22C_A28E;
          1: return 32'h839C_832C;
          2: return 32'h7048_703A;
          3: return 32'h54B8_54C6;
          4: return 32'h4164_41D4;
          5: return 32'h23D4_2372;
          6: return 32'h1080_1080;
          default: return 32'hB480_B480;
        endcase
      end
      2'd1: begin
        y = 8'(16 + 28 * bar);
        return {y, 8'h80, y, 8'h80};
      end
      2'd2: return s;
      default: return ((((col >> CHK) ^ (row >> CHK)) & 1) == 1) ? 32'hB480_B480 : 32'h1080_1080;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_word(input int budget, input string name);
    int left = budget;
    while (q.size() == 0 && left > 0) begin
      step();
      left--;
    end
    if (q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: no word written within %0d cycles", name, budget);
    end
  endtask

  // Consumes n words, comparing each with the model; optionally toggles
  // fifo_full at random with the given percentage.
  task automatic check_stream(input int n, input int full_pct);
    int          got = 0;
    int          budget = n * 8 + 200;
    word_t       w;
    logic [31:0] exp;
    while (got < n && budget > 0) begin
      step();
      budget--;
      while (q.size() > 0 && got < n) begin
        w = q.pop_front();
        got++;
        if (exp_col == 0 && exp_row == 0) begin
          frame_mode  = next_mode;
          frame_solid = next_solid;
          if (words_since_sof >= 0) begin
            checks++;
            if (words_since_sof != H * V) begin
              fails++;
              $display("FAIL sof_period: got %0d words between sof, expected %0d", words_since_sof, H * V);
            end
          end
          words_since_sof = 0;
        end
        exp = model_word(frame_mode, frame_solid, exp_col, exp_row);
        checks++;
        if (w.data !== exp) begin
          fails++;
          $display("FAIL data r%0d c%0d: got %h expected %h", exp_row, exp_col, w.data, exp);
        end
        checks++;
        if (w.sof !== (exp_col == 0 && exp_row == 0)) begin
          fails++;
          $display("FAIL sof r%0d c%0d: got %b", exp_row, exp_col, w.sof);
        end
        checks++;
        if (w.eol !== (exp_col == H - 1)) begin
          fails++;
          $display("FAIL eol r%0d c%0d: got %b", exp_row, exp_col, w.eol);
        end
        words_since_sof++;
        last_stamp = w.stamp;
        exp_col++;
        if (exp_col == H) begin
          exp_col = 0;
          exp_row = (exp_row + 1) % V;
        end
      end
      if (full_pct > 0) bus.fifo_full = ($urandom_range(99) < full_pct);
    end
    bus.fifo_full = 1'b0;
    if (got < n) begin
      checks++;
      fails++;
      $display("FAIL stream_timeout: got %0d words expected %0d", got, n);
    end
  endtask

  task automatic test_reset();
    bus.fifo_wrusedw = '0;
    bus.fifo_full    = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    checks += 4;
    if (bus.fifo_wrreq !== 1'b0) begin fails++; $display("FAIL reset_wrreq: got %b expected 0", bus.fifo_wrreq); end
    if (bus.fifo_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", bus.fifo_data); end
    if (bus.sof !== 1'b0) begin fails++; $display("FAIL reset_sof: got %b expected 0", bus.sof); end
    if (bus.eol !== 1'b0) begin fails++; $display("FAIL reset_eol: got %b expected 0", bus.eol); end
    rst_n = 1'b1;
    repeat (12) step();
    checks++;
    if (q.size() != 0) begin fails++; $display("FAIL no_init_idle: got %0d words expected 0", q.size()); end
  endtask

  int t_eol;

  task automatic test_startup_latency();
    int c0;
    mode = 2'd0;
    solid_color = $urandom;
    next_mode = mode;
    next_solid = solid_color;
    da_init_done = 1'b1;
    c0 = cyc;
    wait_word(40, "startup");
    if (q.size() > 0) begin
      checks++;
      if (q[0].stamp != c0 + 5) begin
        fails++;
        $display("FAIL startup_latency: got %0d cycles expected 5", q[0].stamp - c0);
      end
    end
    check_stream(H, 0);
    t_eol = last_stamp;
  endtask

  task automatic test_line_gap();
    wait_word(40, "line_gap");
    if (q.size() > 0) begin
      checks++;
      if (q[0].stamp != t_eol + 3) begin
        fails++;
        $display("FAIL line_gap: got %0d idle cycles expected 2", q[0].stamp - t_eol - 1);
      end
    end
  endtask

  task automatic test_stall_burst();
    int t19;
    check_stream(20 - exp_col, 0);
    t19 = last_stamp;
    bus.fifo_full = 1'b1;
    repeat (3) step();
    checks++;
    if (q.size() != 0) begin fails++; $display("FAIL stall_issue: got %0d words during full, expected 0", q.size()); end
    bus.fifo_full = 1'b0;
    wait_word(20, "stall_resume");
    if (q.size() > 0) begin
      checks++;
      if (q[0].stamp != t19 + 4) begin
        fails++;
        $display("FAIL stall_gap: got %0d low cycles expected 3", q[0].stamp - t19 - 1);
      end
    end
    check_stream(H - exp_col, 0);
  endtask

  task automatic test_usedw_gate();
    int c1;
    bus.fifo_wrusedw = UW'(DEPTH - H + 1);
    repeat (20) step();
    checks++;
    if (q.size() != 0) begin fails++; $display("FAIL usedw_block: got %0d words expected 0", q.size()); end
    c1 = cyc;
    bus.fifo_wrusedw = UW'(DEPTH - H);
    wait_word(20, "usedw_release");
    if (q.size() > 0) begin
      checks++;
      if (q[0].stamp != c1 + 2) begin
        fails++;
        $display("FAIL usedw_release: got %0d cycles expected 2", q[0].stamp - c1);
      end
    end
    bus.fifo_wrusedw = '0;
    check_stream(H, 25);
  endtask

  task automatic test_mode_switch();
    check_stream(3 * H + 7, 25);
    mode = 2'd2;
    solid_color = 32'h1234_5678;
    next_mode = mode;
    next_solid = solid_color;
    check_stream(H * V - (exp_row * H + exp_col), 25);
    check_stream(H * V / 2, 25);
    mode = 2'd3;
    next_mode = mode;
    check_stream(H * V / 2, 25);
  endtask

  task automatic test_checkerboard();
    check_stream(H * V / 2, 0);
    mode = 2'($urandom_range(0, 3));
    solid_color = $urandom;
    next_mode = mode;
    next_solid = solid_color;
    check_stream(H * V / 2, 0);
  endtask

  task automatic test_init_drop();
    check_stream(H * V / 2 + 5, 20);
    da_init_done = 1'b0;
    check_stream(H * V - (exp_row * H + exp_col), 20);
    repeat (150) step();
    checks++;
    if (q.size() != 0) begin fails++; $display("FAIL init_drop_idle: got %0d words expected 0", q.size()); end
  endtask

  task automatic test_reset_midline();
    int c2;
    mode = 2'($urandom_range(0, 3));
    solid_color = $urandom;
    next_mode = mode;
    next_solid = solid_color;
    da_init_done = 1'b1;
    wait_word(40, "restart");
    check_stream(3 * H + 10, 0);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.fifo_wrreq !== 1'b0) begin fails++; $display("FAIL async_reset_wrreq: got %b expected 0", bus.fifo_wrreq); end
    if (bus.fifo_data !== 32'h0) begin fails++; $display("FAIL async_reset_data: got %h expected 0", bus.fifo_data); end
    q.delete();
    exp_col = 0;
    exp_row = 0;
    words_since_sof = -1;
    mode = 2'($urandom_range(0, 3));
    solid_color = $urandom;
    next_mode = mode;
    next_solid = solid_color;
    repeat (3) step();
    rst_n = 1'b1;
    c2 = cyc;
    wait_word(40, "reset_restart");
    if (q.size() > 0) begin
      checks += 2;
      if (q[0].stamp != c2 + 5) begin
        fails++;
        $display("FAIL reset_restart_latency: got %0d cycles expected 5", q[0].stamp - c2);
      end
      if (q[0].sof !== 1'b1) begin
        fails++;
        $display("FAIL reset_restart_sof: got %b expected 1", q[0].sof);
      end
    end
    check_stream(2 * H, 25);
  endtask

  task automatic test_output_rules();
    checks += 3;
    if (stall_viol != 0) begin fails++; $display("FAIL write_while_full: got %0d expected 0", stall_viol); end
    if (idle_nonzero != 0) begin fails++; $display("FAIL idle_outputs: got %0d nonzero cycles expected 0", idle_nonzero); end
    if (sof_eol_both != 0) begin fails++; $display("FAIL sof_eol_both: got %0d expected 0", sof_eol_both); end
  endtask

  initial begin
    test_reset();
    test_startup_latency();
    test_line_gap();
    test_stall_burst();
    test_usedw_gate();
    test_mode_switch();
    test_checkerboard();
    test_init_drop();
    test_reset_midline();
    test_output_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
